// File: rtl/rps_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rps_pkg: shared round-result, match-state and winner codes         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rps_pkg;
  localparam logic [1:0] RES_TIE  = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_INV  = 2'b11;

  localparam logic [1:0] MS_IDLE  = 2'b00;
  localparam logic [1:0] MS_PLAY  = 2'b01;
  localparam logic [1:0] MS_DONE  = 2'b10;

  localparam logic [1:0] WIN_DRAW = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
endpackage
`default_nettype wire

// File: rtl/rps_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rps_sat_counter: W-bit counter with clear, increment and optional  |
// | saturation at all-ones.                        Revision: 1.0       |
// +--------------------------------------------------------------------+
module rps_sat_counter #(
  parameter int W        = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !(SATURATE && (&count))) begin
      count <= count + W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/rps_match_scorer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rps_match_scorer: accumulates round verdicts into a match result.  |
// | Optional RPS_SCORE_HISTORY_EN adds last-4-rounds history output.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 2,
  parameter int MAX_ROUNDS = 5,
  parameter int SCORE_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_match,
  input  logic               result_valid,
  input  logic [1:0]         result,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] round_cnt,
  output logic [SCORE_W-1:0] invalid_cnt,
  output logic [1:0]         match_state,
  output logic               match_done,
  output logic [1:0]         match_winner
`ifdef RPS_SCORE_HISTORY_EN
  ,
  output logic [7:0]         history
`endif
);
  localparam logic [SCORE_W-1:0] c_win_target = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] c_max_rounds = SCORE_W'(MAX_ROUNDS);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [1:0]         r_winner;
  logic [1:0]         w_winner_next;
  logic               w_play_res;
  logic               w_p1_inc, w_p2_inc, w_rnd_inc, w_inv_inc;
  logic [SCORE_W-1:0] w_p1_post, w_p2_post, w_rnd_post;

  // new_match outranks any result arriving in the same cycle
  assign w_play_res = (r_state == MS_PLAY) && result_valid && !new_match;
  assign w_p1_inc   = w_play_res && (result == RES_P1);
  assign w_p2_inc   = w_play_res && (result == RES_P2);
  assign w_inv_inc  = w_play_res && (result == RES_INV);
  assign w_rnd_inc  = w_play_res && (result != RES_INV);

  assign w_p1_post  = p1_score  + SCORE_W'(w_p1_inc);
  assign w_p2_post  = p2_score  + SCORE_W'(w_p2_inc);
  assign w_rnd_post = round_cnt + SCORE_W'(w_rnd_inc);

  rps_sat_counter #(.W(SCORE_W), .SATURATE(1'b0)) u_p1_cnt (
    .clk(clk), .reset(reset), .clear(new_match), .inc(w_p1_inc), .count(p1_score));
  rps_sat_counter #(.W(SCORE_W), .SATURATE(1'b0)) u_p2_cnt (
    .clk(clk), .reset(reset), .clear(new_match), .inc(w_p2_inc), .count(p2_score));
  rps_sat_counter #(.W(SCORE_W), .SATURATE(1'b0)) u_rnd_cnt (
    .clk(clk), .reset(reset), .clear(new_match), .inc(w_rnd_inc), .count(round_cnt));
  rps_sat_counter #(.W(SCORE_W), .SATURATE(1'b1)) u_inv_cnt (
    .clk(clk), .reset(reset), .clear(new_match), .inc(w_inv_inc), .count(invalid_cnt));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= MS_IDLE;
      r_winner <= WIN_DRAW;
    end else begin
      r_state  <= w_state_next;
      r_winner <= w_winner_next;
    end
  end

  // Match end is judged on post-update counts so done rises with the deciding score
  always_comb begin
    w_state_next = MS_IDLE;
    if (new_match) begin
      w_state_next = MS_PLAY;
    end else begin
      case (r_state)
        MS_IDLE: w_state_next = MS_IDLE;
        MS_PLAY: begin
          if ((w_p1_post == c_win_target) || (w_p2_post == c_win_target) ||
              (w_rnd_post == c_max_rounds))
            w_state_next = MS_DONE;
          else
            w_state_next = MS_PLAY;
        end
        MS_DONE: w_state_next = MS_DONE;
        default: w_state_next = MS_IDLE;
      endcase
    end
  end

  always_comb begin
    w_winner_next = WIN_DRAW;
    if (w_state_next == MS_DONE) begin
      if (r_state == MS_DONE)            w_winner_next = r_winner;
      else if (w_p1_post == c_win_target) w_winner_next = WIN_P1;
      else if (w_p2_post == c_win_target) w_winner_next = WIN_P2;
      else if (w_p1_post > w_p2_post)     w_winner_next = WIN_P1;
      else if (w_p2_post > w_p1_post)     w_winner_next = WIN_P2;
      else                                w_winner_next = WIN_DRAW;
    end
  end

  always_comb begin
    match_state  = r_state;
    match_done   = (r_state == MS_DONE);
    match_winner = r_winner;
  end

`ifdef RPS_SCORE_HISTORY_EN
  always_ff @(posedge clk) begin
    if (reset || new_match) begin
      history <= '0;
    end else if (w_rnd_inc) begin
      history <= {history[5:0], result};
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_rps_match_scorer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rps_match_scorer: directed stimulus, cycle-by-cycle model check |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rps_match_scorer;
  localparam int WIN_TARGET = 2;
  localparam int MAX_ROUNDS = 5;
  localparam int SCORE_W    = 3;
  localparam int INV_MAX    = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               new_match = 1'b0;
  logic               result_valid = 1'b0;
  logic [1:0]         result = 2'b00;
  logic [SCORE_W-1:0] p1_score, p2_score, round_cnt, invalid_cnt;
  logic [1:0]         match_state, match_winner;
  logic               match_done;
`ifdef RPS_SCORE_HISTORY_EN
  logic [7:0]         history;
`endif

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  rps_match_scorer #(.WIN_TARGET(WIN_TARGET), .MAX_ROUNDS(MAX_ROUNDS), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .reset(reset), .new_match(new_match), .result_valid(result_valid),
    .result(result), .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
    .invalid_cnt(invalid_cnt), .match_state(match_state), .match_done(match_done),
    .match_winner(match_winner)
`ifdef RPS_SCORE_HISTORY_EN
    , .history(history)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: match rules on plain integers (state 0 idle, 1 play, 2 done)
  int m_state = 0, m_p1 = 0, m_p2 = 0, m_rnd = 0, m_inv = 0, m_win = 0;
  int m_hist[$];

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_p1 = 0; m_p2 = 0; m_rnd = 0; m_inv = 0; m_win = 0; m_hist = {};
    end else if (new_match) begin
      m_state = 1; m_p1 = 0; m_p2 = 0; m_rnd = 0; m_inv = 0; m_win = 0; m_hist = {};
    end else if (m_state == 1 && result_valid) begin
      if (result == 2'b11) begin
        if (m_inv < INV_MAX) m_inv = m_inv + 1;
      end else begin
        m_rnd = m_rnd + 1;
        if (result == 2'b01) m_p1 = m_p1 + 1;
        if (result == 2'b10) m_p2 = m_p2 + 1;
        m_hist.push_front(int'(result));
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        if (m_p1 == WIN_TARGET) begin
          m_state = 2; m_win = 1;
        end else if (m_p2 == WIN_TARGET) begin
          m_state = 2; m_win = 2;
        end else if (m_rnd == MAX_ROUNDS) begin
          m_state = 2;
          m_win = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 0;
        end
      end
    end
  end

  function automatic int model_hist();
    int h = 0;
    for (int i = 0; i < m_hist.size(); i++) h = h | (m_hist[i] << (2 * i));
    return h;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model p1_score", 32'(p1_score), m_p1);
      chk("model p2_score", 32'(p2_score), m_p2);
      chk("model round_cnt", 32'(round_cnt), m_rnd);
      chk("model invalid_cnt", 32'(invalid_cnt), m_inv);
      chk("model match_state", 32'(match_state), m_state);
      chk("model match_done", 32'(match_done), (m_state == 2) ? 1 : 0);
      chk("model match_winner", 32'(match_winner), m_win);
`ifdef RPS_SCORE_HISTORY_EN
      chk("model history", 32'(history), model_hist());
`endif
    end
  end

  task automatic cyc(input logic nm, input logic rv, input logic [1:0] r, input logic rs);
    new_match = nm; result_valid = rv; result = r; reset = rs;
    @(posedge clk);
    #2;
    new_match = 1'b0; result_valid = 1'b0; result = 2'b00; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    #2;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset state", 32'(match_state), 0);
    chk("reset p1", 32'(p1_score), 0);

    // 1: results ignored in IDLE
    cyc(0, 1, 2'b01, 0);
    chk("idle ignores p1", 32'(p1_score), 0);
    chk("idle ignores rnd", 32'(round_cnt), 0);
    chk("idle state", 32'(match_state), 0);

    // 2: P1 takes the match on the third counted round
    cyc(1, 0, 2'b00, 0);
    chk("new_match state", 32'(match_state), 1);
    cyc(0, 1, 2'b01, 0);
    cyc(0, 1, 2'b00, 0);
    chk("not done yet", 32'(match_done), 0);
    cyc(0, 1, 2'b01, 0);
    chk("t2 p1", 32'(p1_score), 2);
    chk("t2 rnd", 32'(round_cnt), 3);
    chk("t2 done", 32'(match_done), 1);
    chk("t2 winner", 32'(match_winner), 1);
    cyc(0, 1, 2'b10, 0);
    chk("done ignores p2", 32'(p2_score), 0);
    chk("done holds winner", 32'(match_winner), 1);

    // 3: round limit reached with level scores
    cyc(1, 0, 2'b00, 0);
    chk("winner cleared", 32'(match_winner), 0);
    chk("done cleared", 32'(match_done), 0);
    cyc(0, 1, 2'b01, 0);
    cyc(0, 1, 2'b10, 0);
    cyc(0, 1, 2'b00, 0);
    cyc(0, 1, 2'b00, 0);
    chk("t3 before limit", 32'(match_done), 0);
    cyc(0, 1, 2'b00, 0);
    chk("t3 rnd", 32'(round_cnt), 5);
    chk("t3 p1", 32'(p1_score), 1);
    chk("t3 p2", 32'(p2_score), 1);
    chk("t3 state", 32'(match_state), 2);
    chk("t3 winner", 32'(match_winner), 0);

    // 4: invalid counter saturates, P2 wins
    cyc(1, 0, 2'b00, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 2'b11, 0);
    chk("t4 inv sat", 32'(invalid_cnt), 7);
    chk("t4 inv no round", 32'(round_cnt), 0);
    cyc(0, 1, 2'b10, 0);
    cyc(0, 1, 2'b10, 0);
    chk("t4 inv hold", 32'(invalid_cnt), 7);
    chk("t4 rnd", 32'(round_cnt), 2);
    chk("t4 winner", 32'(match_winner), 2);
    chk("t4 done", 32'(match_done), 1);

    // 5: new_match beats a coincident result mid-match
    cyc(1, 0, 2'b00, 0);
    cyc(0, 1, 2'b01, 0);
    chk("t5 p1 pre", 32'(p1_score), 1);
    cyc(1, 1, 2'b01, 0);
    chk("t5 p1 dropped", 32'(p1_score), 0);
    chk("t5 rnd", 32'(round_cnt), 0);
    chk("t5 state", 32'(match_state), 1);

    // 6: reset beats a coincident result
    cyc(0, 1, 2'b10, 0);
    chk("t6 p2 pre", 32'(p2_score), 1);
    cyc(0, 1, 2'b10, 1);
    chk("t6 p2", 32'(p2_score), 0);
    chk("t6 state", 32'(match_state), 0);
    chk("t6 winner", 32'(match_winner), 0);

    // History order: newest result in the low bits
    cyc(1, 0, 2'b00, 0);
    cyc(0, 1, 2'b01, 0);
    cyc(0, 1, 2'b11, 0);
    cyc(0, 1, 2'b00, 0);
    cyc(0, 1, 2'b10, 0);
    chk("hist p1", 32'(p1_score), 1);
    chk("hist inv", 32'(invalid_cnt), 1);
`ifdef RPS_SCORE_HISTORY_EN
    chk("history literal", 32'(history), 32'h12);
`endif

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rps_match_scorer.md
Name: rps_match_scorer

Overview:
Downstream consumer of the rock-paper-scissors round evaluator. Takes one 2-bit round verdict per valid pulse and accumulates per-player scores, tie and invalid counts. Declares a match winner when a player reaches WIN_TARGET or the round limit is hit. Feeds the display/LED stage with registered scores and match status.

Parameters:
WIN_TARGET, 2, wins needed to take the match (best-of-3 default); legal range 1 to 2^SCORE_W-1.
MAX_ROUNDS, 5, counted rounds (wins plus ties) after which the match ends regardless; must be >= WIN_TARGET.
SCORE_W, 3, width of the score and counter outputs.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
new_match  input  1  one-cycle pulse; clears counters and starts a match
result_valid  input  1  one-cycle pulse; result is valid this cycle
result  input  2  00 tie, 01 P1 win, 10 P2 win, 11 invalid
p1_score  output  SCORE_W  P1 round wins
p2_score  output  SCORE_W  P2 round wins
round_cnt  output  SCORE_W  counted rounds (ties plus wins)
invalid_cnt  output  SCORE_W  invalid verdicts, saturating
match_state  output  2  00 IDLE, 01 PLAY, 10 DONE
match_done  output  1  high while in DONE
match_winner  output  2  00 draw, 01 P1, 10 P2; 00 unless match_done

Behaviour:
- All outputs are registered. Reset (sync, active-high, highest priority) sets every output to 0 and the state to IDLE.
- IDLE: result_valid is ignored. new_match moves to PLAY with all counters at 0.
- PLAY: on a result_valid cycle, counters update at that clock edge and are visible the next cycle (1-cycle latency).
  - 01: p1_score+1 and round_cnt+1.
  - 10: p2_score+1 and round_cnt+1.
  - 00: round_cnt+1 only.
  - 11: invalid_cnt+1, saturating at all-ones. Not a round; state unchanged.
- PLAY to DONE is evaluated on the post-update values in the same edge, so match_done rises in the same cycle the deciding score appears.
  - A player's score == WIN_TARGET: DONE, match_winner is that player.
  - Otherwise round_cnt == MAX_ROUNDS: DONE, match_winner is the higher score, or 00 if scores are equal.
  - A target win takes precedence over the round limit when both occur on the same result.
- DONE: result_valid is ignored and all counters hold. new_match returns to PLAY with counters cleared and match_winner cleared to 00.
- new_match and result_valid in the same cycle (any state): new_match wins, the result is discarded, and the state becomes PLAY with zeros.
- new_match mid-PLAY: aborts the match and restarts with zeros; no DONE is produced.
- Scores cannot overflow because WIN_TARGET and MAX_ROUNDS fit in SCORE_W. invalid_cnt saturates and never wraps.
- Unused state encoding 11: next state is IDLE.

Optional Feature:
Macro RPS_SCORE_HISTORY_EN.
- Defined:
  - Adds output history, 8 bits wide: the last 4 counted-round results as a shift register, newest in [1:0].
  - Shifts on every counted round in PLAY; invalid results do not shift.
  - Cleared by reset and new_match; held in DONE.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package rps_pkg holds:
  - result codes: RES_TIE=2'b00, RES_P1=2'b01, RES_P2=2'b10, RES_INV=2'b11;
  - match_state encodings: MS_IDLE, MS_PLAY, MS_DONE;
  - the winner codes. The upstream evaluator imports the same codes.
- One natural sub-module: rps_sat_counter, a SCORE_W-wide counter with clear, increment and saturate. It is instantiated four times for p1, p2, round and invalid; saturation is enabled only for the invalid counter.

Test Plan:
Defaults (WIN_TARGET=2, MAX_ROUNDS=5) unless noted.
1. Reset, then result_valid with 01 in IDLE -> all outputs stay 0 and match_state=00.
2. new_match, then results 01,00,01 -> after the third: p1_score=2, round_cnt=3, match_done=1 in the same cycle, match_winner=01; a further 10 is ignored.
3. new_match, then 01,10,00,00,00 -> after the fifth: round_cnt=5, p1=p2=1, DONE, match_winner=00.
4. new_match, then 11 ten times, then 10,10 -> invalid_cnt holds at 7 (saturated), round_cnt=2, match_winner=10.
5. Mid-match with p1=1: drive new_match and result_valid=01 in the same cycle -> next cycle all counters are 0, PLAY, and the result is dropped.
6. In PLAY with p2=1, assert reset together with result_valid=10 -> next cycle all outputs 0 and IDLE. With RPS_SCORE_HISTORY_EN: after 01,00,10 in PLAY, history=8'b00_01_00_10.
